ddr3_refresh_fsm: RTL
=====================

Name: ddr3_refresh_fsm

Overview:
Refresh scheduler that sits directly upstream of ddr3_cmd_gen and drives its refresh_req path. It counts tREFI intervals and tracks outstanding refresh debt. When debt exists it drains the bank FSMs, issues PRECHARGE-all if any row is open, then issues REFRESH and enforces tRP/tRFC. Bank FSMs read ref_pending to stop new ACTIVATEs.

Parameters:
T_REFI_CYC, 780, tREFI in clk cycles (7.8 us at 100 MHz)
T_RFC_CYC, 11, tRFC in clk cycles
T_RP_CYC, 2, tRP in clk cycles
MAX_POSTPONE, 8, maximum refresh debt (JEDEC postpone limit)
URGENT_THRESH, 6, debt level at which ref_urgent asserts

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
init_done  in  1  DDR3 init sequence complete; gates the tREFI timer
bank_idle  in  4  per-bank FSM idle, no access in flight
bank_open  in  4  per-bank row open
cmd_accepted  in  1  ddr3_cmd_gen issued the presented refresh-path command this cycle
refresh_req  out  1  to ddr3_cmd_gen: command valid
ref_cmd_type  out  ddr3_cmd_t  PRECHARGE or REFRESH; NOP when idle
ref_addr  out  13  13'h0400 (A10=1) for PRECHARGE-all, else 0
ref_pending  out  1  to bank FSMs: finish current access, open no new rows
ref_urgent  out  1  debt >= URGENT_THRESH
ref_debt  out  4  outstanding refresh count
ref_overflow  out  1  sticky: tick arrived with debt == MAX_POSTPONE

Behaviour:
- Reset (async): state IDLE, timer 0, debt 0. All outputs 0; ref_cmd_type=NOP.
- Timer: counts only while init_done=1. Range 0..T_REFI_CYC-1. On wrap it emits a 1-cycle tick.
- Debt accounting:
  - Tick increments debt.
  - REFRESH accepted (cmd_accepted=1 in REFRESH state) decrements debt.
  - Tick and REFRESH accept in the same cycle: debt unchanged.
  - Tick with debt==MAX_POSTPONE and no decrement: debt holds and ref_overflow sets. ref_overflow clears only on rst.
- ref_pending is registered. It is 1 in every state except IDLE.
- States:
  - IDLE: go to DRAIN when debt>0.
  - DRAIN: wait for bank_idle==4'hF, sampled the same edge. Then go to PRECHARGE if |bank_open, else REFRESH.
  - PRECHARGE: refresh_req=1, ref_cmd_type=PRECHARGE, ref_addr=13'h0400. On cmd_accepted go to WAIT_RP and load cnt=T_RP_CYC-1.
  - WAIT_RP: decrement cnt; at 0 go to REFRESH. REFRESH is presented T_RP_CYC edges after the accept edge.
  - REFRESH: refresh_req=1, ref_cmd_type=REFRESH, ref_addr=0. On cmd_accepted go to WAIT_RFC and load cnt=T_RFC_CYC-1.
  - WAIT_RFC: decrement cnt; at 0 go to REFRESH if debt>0 (banks are still closed, so no precharge), else IDLE.
- Handshake:
  - refresh_req, ref_cmd_type and ref_addr stay stable while refresh_req=1 and cmd_accepted=0.
  - cmd_accepted is ignored when refresh_req=0.
  - refresh_req drops the cycle after the accept edge.
- init_done deassert: freezes the timer only. An in-flight sequence still completes.
- Reset mid-sequence: immediate return to IDLE with all outputs 0, even if a command is being presented.

Decomposition:
- ddr3_pkg contents:
  - ddr3_cmd_t with PRECHARGE and REFRESH encodings (add them if absent).
  - ref_state_t enum {IDLE, DRAIN, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC}.
  - Default timing constants.
  - PRECHARGE_ALL_ADDR = 13'h0400.
- Sub-module ddr3_refi_timer: enabled wrap counter producing the tick.

Test Plan (T_REFI_CYC=20, T_RFC_CYC=5, T_RP_CYC=2, MAX_POSTPONE=4, URGENT_THRESH=3):
- No banks open, bank_idle=F, init_done rises:
  - Tick 20 cycles later: debt=1 and ref_pending=1.
  - Next cycle: refresh_req=1, REFRESH, addr 0.
  - Accept: debt=0; ref_pending falls 5 cycles after the accept edge.
- bank_open=4'b0010: PRECHARGE with addr 13'h0400 first. After accept, refresh_req is low 2 cycles, then REFRESH.
- bank_idle=4'b1110 held 60 cycles:
  - debt reaches 3 and ref_urgent=1; no refresh_req while draining.
  - Release: three REFRESHes, each presented exactly 5 cycles after the previous accept edge.
  - ref_urgent drops when debt falls below 3.
- Drain blocked 100 cycles: debt saturates at 4, ref_overflow=1, and it stays 1 after the debt is repaid.
- cmd_accepted held low 3 cycles with a tick landing on the accept cycle: refresh_req, type and addr stable throughout; debt unchanged across the accept.
- rst pulsed during WAIT_RFC: all outputs 0 and state IDLE before the next clk edge; timer restarts from 0.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared DDR3 controller types and default timing for the refresh path.
// Command encodings are shared with ddr3_cmd_gen.
package ddr3_pkg;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_ACTIVATE  = 3'd1,
        CMD_READ      = 3'd2,
        CMD_WRITE     = 3'd3,
        CMD_PRECHARGE = 3'd4,
        CMD_REFRESH   = 3'd5
    } ddr3_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PRECHARGE,
        WAIT_RP,
        REFRESH,
        WAIT_RFC
    } ref_state_t;

    localparam int T_REFI_CYC_DEF    = 780;
    localparam int T_RFC_CYC_DEF     = 11;
    localparam int T_RP_CYC_DEF      = 2;
    localparam int MAX_POSTPONE_DEF  = 8;
    localparam int URGENT_THRESH_DEF = 6;

    localparam logic [12:0] PRECHARGE_ALL_ADDR = 13'h0400;

endpackage

// File: rtl/ddr3_refi_timer.sv
// Free-running tREFI interval counter; pulses tick_o for one cycle on each wrap.
// Holds its count while en_i is low.
module ddr3_refi_timer #(
    parameter int PERIOD = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap;

    assign wrap = (cnt_q == W'(PERIOD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && wrap;

endmodule

// File: rtl/ddr3_refresh_fsm.sv
// Refresh scheduler: accumulates tREFI debt, drains the banks, closes open rows
// and issues REFRESH commands to ddr3_cmd_gen while honouring tRP and tRFC.
module ddr3_refresh_fsm
    import ddr3_pkg::*;
#(
    parameter int T_REFI_CYC    = T_REFI_CYC_DEF,
    parameter int T_RFC_CYC     = T_RFC_CYC_DEF,
    parameter int T_RP_CYC      = T_RP_CYC_DEF,
    parameter int MAX_POSTPONE  = MAX_POSTPONE_DEF,
    parameter int URGENT_THRESH = URGENT_THRESH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic [3:0]  bank_idle,
    input  logic [3:0]  bank_open,
    input  logic        cmd_accepted,
    output logic        refresh_req,
    output ddr3_cmd_t   ref_cmd_type,
    output logic [12:0] ref_addr,
    output logic        ref_pending,
    output logic        ref_urgent,
    output logic [3:0]  ref_debt,
    output logic        ref_overflow
);

    localparam int CNT_MAX = (T_RFC_CYC > T_RP_CYC) ? T_RFC_CYC : T_RP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ref_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       debt_q, debt_d;
    logic             ovf_q, ovf_d;
    logic             pending_q;
    logic             tick;
    logic             ref_acc;

    ddr3_refi_timer #(
        .PERIOD (T_REFI_CYC)
    ) u_refi_timer (
        .clk    (clk),
        .rst    (rst),
        .en_i   (init_done),
        .tick_o (tick)
    );

    assign ref_acc = (state_q == REFRESH) && cmd_accepted;

    // A tick and a REFRESH accept in the same cycle cancel out.
    always_comb begin
        debt_d = debt_q;
        ovf_d  = ovf_q;
        if (tick && !ref_acc) begin
            if (debt_q == 4'(MAX_POSTPONE)) begin
                ovf_d = 1'b1;
            end else begin
                debt_d = debt_q + 4'd1;
            end
        end else if (!tick && ref_acc) begin
            debt_d = debt_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (debt_d != 4'd0) state_d = DRAIN;
            end
            DRAIN: begin
                if (bank_idle == 4'hF) state_d = (|bank_open) ? PRECHARGE : REFRESH;
            end
            PRECHARGE: begin
                if (cmd_accepted) begin
                    state_d = WAIT_RP;
                    cnt_d   = CNT_W'(T_RP_CYC - 1);
                end
            end
            WAIT_RP: begin
                if (cnt_q == '0) state_d = REFRESH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            REFRESH: begin
                if (cmd_accepted) begin
                    state_d = WAIT_RFC;
                    cnt_d   = CNT_W'(T_RFC_CYC - 1);
                end
            end
            WAIT_RFC: begin
                // Rows are still closed after a refresh, so back-to-back refreshes skip PRECHARGE.
                if (cnt_q == '0) state_d = (debt_d != 4'd0) ? REFRESH : IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            debt_q    <= '0;
            ovf_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            debt_q    <= debt_d;
            ovf_q     <= ovf_d;
            pending_q <= (state_d != IDLE);
        end
    end

    always_comb begin
        refresh_req  = 1'b0;
        ref_cmd_type = CMD_NOP;
        ref_addr     = '0;
        if (state_q == PRECHARGE) begin
            refresh_req  = 1'b1;
            ref_cmd_type = CMD_PRECHARGE;
            ref_addr     = PRECHARGE_ALL_ADDR;
        end else if (state_q == REFRESH) begin
            refresh_req  = 1'b1;
            ref_cmd_type = CMD_REFRESH;
        end
    end

    assign ref_pending  = pending_q;
    assign ref_urgent   = (debt_q >= 4'(URGENT_THRESH));
    assign ref_debt     = debt_q;
    assign ref_overflow = ovf_q;

endmodule
